audio_i2s_tx: RTL and testbench

- Output stage directly downstream of the notch filter.
- Accepts the filter's 8-bit signed samples through a valid/ready push interface into a small FIFO.
- Serialises each sample as mono audio, duplicated on left and right, onto a left-justified I2S-style link (bclk/lrck/sdata) for the audio DAC.
- Generates its own bit clock and word clock from the system clock.

---
 rtl/audio_i2s_tx.sv | 146 ++++++++++++++
 tb/tb_audio_i2s_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// Mono-to-stereo left-justified I2S transmitter with a small sample FIFO.
// Derives bclk/lrck from clk with a divider; one sample feeds both channel slots.
module audio_i2s_tx #(
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned SLOT_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          sample_in,
  input  logic                                sample_valid,
  output logic                                sample_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic                                bclk,
  output logic                                lrck,
  output logic                                sdata,
  output logic                                underrun,
  output logic                                overflow
);

  localparam int unsigned DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned WORD_W = 2 * SLOT_W;
  localparam int unsigned CNT_W  = $clog2(WORD_W);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              bclk_q, bclk_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic              sdata_q, sdata_d;
  logic              lrck_q, lrck_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ready_q, ready_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic              push;
  logic              pop;
  logic              fall;
  logic [SLOT_W-1:0] slot;
  logic [WORD_W-1:0] word;

  // Divider, bit sequencing, frame loading and FIFO bookkeeping
  always_comb begin
    div_d      = div_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    sdata_d    = sdata_q;
    lrck_d     = lrck_q;
    underrun_d = 1'b0;
    overflow_d = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    fall       = 1'b0;
    slot       = '0;
    word       = '0;

    if (div_q == DIV_W'(BCLK_DIV - 1)) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      fall   = bclk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (fall) begin
      if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
        bit_cnt_d = '0;
        if (level_q != '0) begin
          pop  = 1'b1;
          slot = SLOT_W'(mem_q[rd_ptr_q]) << (SLOT_W - 8);
          word = {slot, slot};
        end else begin
          underrun_d = 1'b1;
        end
        sdata_d = word[WORD_W-1];
        sh_d    = word << 1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        sdata_d   = sh_q[WORD_W-1];
        sh_d      = sh_q << 1;
      end
      lrck_d = (bit_cnt_d >= CNT_W'(SLOT_W));
    end

    // Readiness reflects pre-edge occupancy, so a push while full is dropped even on a pop edge
    push       = sample_valid & ready_q;
    overflow_d = sample_valid & ~ready_q;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    ready_d  = (level_d != LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= CNT_W'(WORD_W - 1);
      sh_q       <= '0;
      sdata_q    <= 1'b0;
      lrck_q     <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      sdata_q    <= sdata_d;
      lrck_q     <= lrck_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
    end
  end

  // Sample storage needs no reset; occupancy tracking gates every read
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign sample_ready = ready_q;
  assign fifo_level   = level_q;
  assign bclk         = bclk_q;
  assign lrck         = lrck_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: frame-level reference model plus directed corner sequences.
module tb_audio_i2s_tx;

  localparam int BD = 4;
  localparam int SW = 16;
  localparam int FD = 4;
  localparam int FALL_P = 2 * BD;
  localparam int BITS = 2 * SW;

  logic       clk;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic [2:0] fifo_level;
  logic       bclk, lrck, sdata, underrun, overflow;

  audio_i2s_tx #(.BCLK_DIV(BD), .SLOT_W(SW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .fifo_level(fifo_level), .bclk(bclk),
    .lrck(lrck), .sdata(sdata), .underrun(underrun), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: edge count since reset, sample queue, current frame word
  int          t;
  logic [7:0]  q[$];
  logic [31:0] cur_word;
  logic        exp_und, exp_ovf;

  // Observed stream capture
  logic [31:0] capd, capl;
  logic [31:0] frames[$];
  logic [31:0] lrks[$];
  int          und_edges[$];
  int          rises;
  logic        prev_bclk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    int         lvl;
    logic       rdy;
    logic       ovf;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: actual=0x%0h expected=0x%0h", nm, t, act, exp);
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    int pre;
    logic [7:0] s;
    t++;
    exp_und = 1'b0;
    exp_ovf = 1'b0;
    pre = q.size();
    if (t % FALL_P == 0 && ((t / FALL_P - 1) % BITS) == 0) begin
      if (pre > 0) begin
        s = q.pop_front();
        cur_word = {s, 8'h00, s, 8'h00};
      end else begin
        cur_word = 32'h0;
        exp_und = 1'b1;
      end
    end
    if (v) begin
      if (pre < FD) q.push_back(d);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    int f, k;
    logic el, es;
    f = t / FALL_P;
    if (f == 0) begin
      el = 1'b0;
      es = 1'b0;
    end else begin
      k = (f - 1) % BITS;
      el = (k >= SW);
      es = cur_word[31-k];
    end
    chk("bclk", 32'(bclk), 32'((t / BD) % 2));
    chk("lrck", 32'(lrck), 32'(el));
    chk("sdata", 32'(sdata), 32'(es));
    chk("underrun", 32'(underrun), 32'(exp_und));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("sample_ready", 32'(sample_ready), 32'(q.size() < FD));
  endtask

  task automatic record();
    int k;
    if (t > 0 && t % FALL_P == 0) begin
      k = (t / FALL_P - 1) % BITS;
      capd[31-k] = sdata;
      capl[31-k] = lrck;
      if (k == BITS - 1) begin
        frames.push_back(capd);
        lrks.push_back(capl);
      end
    end
    if (underrun === 1'b1) und_edges.push_back(t);
    if (bclk === 1'b1 && prev_bclk === 1'b0) rises++;
    prev_bclk = bclk;
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    sample_valid = v;
    sample_in    = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    check_all();
    record();
    sample_valid = 1'b0;
  endtask

  task automatic idle_to(input int last_edge);
    while (t < last_edge) tick(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = 8'h00;
    @(posedge clk);
    #1;
    chk("rst_bclk", 32'(bclk), 32'd0);
    chk("rst_lrck", 32'(lrck), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    rst = 1'b0;
    t = 0;
    q.delete();
    cur_word = 32'h0;
    frames.delete();
    lrks.delete();
    und_edges.delete();
    rises = 0;
    prev_bclk = 1'b0;
    capd = 32'h0;
    capl = 32'h0;
  endtask

  initial begin
    tbl[0] = '{v: 1'b1, d: 8'h11, lvl: 1, rdy: 1'b1, ovf: 1'b0};
    tbl[1] = '{v: 1'b1, d: 8'h22, lvl: 2, rdy: 1'b1, ovf: 1'b0};
    tbl[2] = '{v: 1'b1, d: 8'h33, lvl: 3, rdy: 1'b1, ovf: 1'b0};
    tbl[3] = '{v: 1'b1, d: 8'h44, lvl: 4, rdy: 1'b0, ovf: 1'b0};
    tbl[4] = '{v: 1'b1, d: 8'h55, lvl: 4, rdy: 1'b0, ovf: 1'b1};

    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = 8'h00;
    t = 0;
    cur_word = 32'h0;
    repeat (2) @(posedge clk);

    // Single 0x5A sample, both slots identical
    do_reset();
    tick(1'b1, 8'h5A);
    chk("a_level_e1", 32'(fifo_level), 32'd1);
    idle_to(7);
    chk("a_level_e7", 32'(fifo_level), 32'd1);
    tick(1'b0, 8'h00);
    chk("a_level_e8", 32'(fifo_level), 32'd0);
    idle_to(263);
    chk("a_nframes", 32'(frames.size()), 32'd1);
    chk("a_frame", frames[0], 32'h5A005A00);
    chk("a_lrck_bits", lrks[0], 32'h0000FFFF);
    chk("a_no_underrun", 32'(und_edges.size()), 32'd0);

    // Extremes of the signed range
    do_reset();
    tick(1'b1, 8'h80);
    tick(1'b1, 8'h7F);
    idle_to(512);
    chk("b_nframes", 32'(frames.size()), 32'd2);
    chk("b_frame1", frames[0], 32'h80008000);
    chk("b_frame2", frames[1], 32'h7F007F00);

    // No input: silence, underrun once per frame
    do_reset();
    idle_to(520);
    chk("c_nund", 32'(und_edges.size()), 32'd3);
    chk("c_und0", 32'(und_edges[0]), 32'd8);
    chk("c_und1", 32'(und_edges[1]), 32'd264);
    chk("c_und2", 32'(und_edges[2]), 32'd520);
    chk("c_bclk_rises", 32'(rises), 32'd65);
    chk("c_frame_zero", frames[0], 32'h0);

    // Fill to full, fifth push dropped
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(tbl[i].v, tbl[i].d);
      chk("d_level", 32'(fifo_level), 32'(tbl[i].lvl));
      chk("d_ready", 32'(sample_ready), 32'(tbl[i].rdy));
      chk("d_overflow", 32'(overflow), 32'(tbl[i].ovf));
    end
    idle_to(1024);
    chk("d_nframes", 32'(frames.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("d_frame", frames[i], {tbl[i].d, 8'h00, tbl[i].d, 8'h00});

    // Push while full exactly on a load edge
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'hA1 + 8'(i));
    idle_to(8);
    tick(1'b1, 8'hA5);
    chk("e_full", 32'(sample_ready), 32'd0);
    idle_to(263);
    tick(1'b1, 8'h99);
    chk("e_ovf_load", 32'(overflow), 32'd1);
    chk("e_level_load", 32'(fifo_level), 32'd3);
    tick(1'b1, 8'hAB);
    chk("e_accept_after", 32'(fifo_level), 32'd4);
    chk("e_no_ovf_after", 32'(overflow), 32'd0);
    idle_to(1536);
    chk("e_nframes", 32'(frames.size()), 32'd6);
    chk("e_frame5", frames[5], 32'hAB00AB00);
    chk("e_frame4", frames[4], 32'hA500A500);

    // Reset in the right slot with samples pending
    do_reset();
    tick(1'b1, 8'h31);
    tick(1'b1, 8'h32);
    tick(1'b1, 8'h33);
    idle_to(168);
    chk("f_lrck_before", 32'(lrck), 32'd1);
    chk("f_level_before", 32'(fifo_level), 32'd2);
    do_reset();
    idle_to(256);
    chk("f_und_count", 32'(und_edges.size()), 32'd1);
    chk("f_und_edge", 32'(und_edges[0]), 32'd8);
    chk("f_frame_zero", frames[0], 32'h0);

    // Randomised traffic against the model, alternating light and heavy load
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic v;
      v = ($urandom_range(0, 299) < (((i / 500) % 2 == 1) ? 6 : 1));
      tick(v, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
